// File: rtl/f7_sched_if.sv
// f7_sched_if: handshake and read-address/strobe bundle between the F7 layer
// controller (master) and the F7 sequencer (slave).
//   start, hold             : controller -> sequencer
//   busy, done              : sequencer -> controller status
//   w7_raddr, x_raddr       : weight ROM / feature buffer read addresses
//   mac_en, mac_first, mac_last : accumulator strobes aligned with read data
interface f7_sched_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              start;
    logic              hold;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] w7_raddr;
    logic [ADDR_W-1:0] x_raddr;
    logic              mac_en;
    logic              mac_first;
    logic              mac_last;

    modport master (
        output start, hold,
        input  busy, done, w7_raddr, x_raddr, mac_en, mac_first, mac_last
    );

    modport slave (
        input  start, hold,
        output busy, done, w7_raddr, x_raddr, mac_en, mac_first, mac_last
    );
endinterface

// File: rtl/f7_sched.sv
// f7_sched: sequencer for the F7 fully-connected layer. Walks the weight ROM and
// the F6 feature buffer one column per cycle and emits MAC strobes aligned with
// the read data of both 1-cycle-per-stage synchronous memories.
//   clk      : clock, rising edge
//   rst      : synchronous reset, active-high
//   bus      : f7_sched_if.slave (start/hold in; busy/done, addresses, MAC strobes out)
module f7_sched #(
    parameter int unsigned N_IN   = 84,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    f7_sched_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(N_IN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_n;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_n;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_n;
    logic [ADDR_W-1:0] w_col;
    logic              w_issue;
    logic              r_busy;
    logic              r_done;

    // Valid pipeline: stage 0 is aligned with the registered address, stage
    // RD_LAT with the memory read data.
    logic [RD_LAT:0]   r_p_en;
    logic [RD_LAT:0]   r_p_first;
    logic [RD_LAT:0]   r_p_last;

    // Next-state / issue decision. The column is issued on the same edge that
    // loads the address register, so an accepted start puts column 0 out at once.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_addr_n  = r_addr;
        w_col     = r_cnt;
        w_issue   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_n = S_RUN;
                    w_cnt_n   = '0;
                    w_col     = '0;
                    w_issue   = !bus.hold;
                end
            end
            S_RUN: begin
                w_issue = !bus.hold;
            end
            S_DRAIN: begin
                if (r_p_last[RD_LAT]) begin
                    w_state_n = S_DONE;
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
        if (w_issue) begin
            w_addr_n = w_col;
            // Counter saturates at the last column rather than wrapping.
            if (w_col == LAST_COL) begin
                w_state_n = S_DRAIN;
            end else begin
                w_cnt_n = w_col + ADDR_W'(1);
            end
        end
    end

    // State, counter, address and strobe pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_p_en    <= '0;
            r_p_first <= '0;
            r_p_last  <= '0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_addr    <= w_addr_n;
            r_busy    <= (w_state_n != S_IDLE);
            r_done    <= (w_state_n == S_DONE);
            r_p_en    <= {r_p_en[RD_LAT-1:0],    w_issue};
            r_p_first <= {r_p_first[RD_LAT-1:0], w_issue && (w_col == '0)};
            r_p_last  <= {r_p_last[RD_LAT-1:0],  w_issue && (w_col == LAST_COL)};
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.w7_raddr  = r_addr;
    assign bus.x_raddr   = r_addr;
    assign bus.mac_en    = r_p_en[RD_LAT];
    assign bus.mac_first = r_p_first[RD_LAT];
    assign bus.mac_last  = r_p_last[RD_LAT];

endmodule

// File: tb/tb_f7_sched.sv
// tb_f7_sched: randomized + directed bench for f7_sched. Two instances:
// A (N_IN=84, ADDR_W=7, RD_LAT=1) and B (N_IN=4, ADDR_W=2, RD_LAT=3).
// A timestamp-based model predicts every output each cycle; directed passes pin
// the model with literal cycle numbers; a ROM/feature model plus accumulators
// checks the resulting dot products.
module tb_f7_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst = 1'b1;
    logic b_rst = 1'b1;

    f7_sched_if #(.ADDR_W(7)) a_if ();
    f7_sched_if #(.ADDR_W(2)) b_if ();

    f7_sched #(.N_IN(84), .ADDR_W(7), .RD_LAT(1)) dut_a (
        .clk (clk),
        .rst (a_rst),
        .bus (a_if.slave)
    );

    f7_sched #(.N_IN(4), .ADDR_W(2), .RD_LAT(3)) dut_b (
        .clk (clk),
        .rst (b_rst),
        .bus (b_if.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_on = 1'b0;
    bit b_rand_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int NI[2] = '{84, 4};
    int RL[2] = '{1, 3};
    int m_busy[2]    = '{0, 0};
    int m_issued[2]  = '{0, 0};
    int m_done_at[2] = '{-10, -10};
    int m_addr[2]    = '{0, 0};
    int strobe_col[longint];
    bit e_busy[2], e_done[2], e_en[2], e_first[2], e_last[2];
    int e_addr[2];

    function automatic longint key(input int c, input int id);
        return longint'(c) * 2 + longint'(id);
    endfunction

    // Called at each edge; cyc is the cycle that begins at this edge.
    task automatic model_step(input int id, input bit r, input bit s, input bit h);
        bit was;
        if (r) begin
            m_busy[id] = 0; m_issued[id] = 0; m_done_at[id] = -10; m_addr[id] = 0;
            for (int k = 0; k < 4; k++) strobe_col.delete(key(cyc + k, id));
        end else begin
            was = (m_busy[id] != 0);
            if (was && m_done_at[id] == cyc - 1) m_busy[id] = 0;
            if (!was && s) begin
                m_busy[id] = 1; m_issued[id] = 0; m_done_at[id] = -10;
            end
            if (m_busy[id] != 0 && m_issued[id] < NI[id] && !h) begin
                m_addr[id] = m_issued[id];
                strobe_col[key(cyc + RL[id], id)] = m_issued[id];
                if (m_issued[id] == NI[id] - 1) m_done_at[id] = cyc + RL[id] + 1;
                m_issued[id]++;
            end
        end
        e_busy[id] = (m_busy[id] != 0);
        e_done[id] = (cyc == m_done_at[id]);
        e_addr[id] = m_addr[id];
        e_en[id] = 1'b0; e_first[id] = 1'b0; e_last[id] = 1'b0;
        if (strobe_col.exists(key(cyc, id))) begin
            e_en[id]    = 1'b1;
            e_first[id] = (strobe_col[key(cyc, id)] == 0);
            e_last[id]  = (strobe_col[key(cyc, id)] == NI[id] - 1);
            strobe_col.delete(key(cyc, id));
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step(0, a_rst, a_if.start, a_if.hold);
        model_step(1, b_rst, b_if.start, b_if.hold);
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_busy",  int'(a_if.busy),      int'(e_busy[0]));
            chk("a_done",  int'(a_if.done),      int'(e_done[0]));
            chk("a_waddr", int'(a_if.w7_raddr),  e_addr[0]);
            chk("a_xaddr", int'(a_if.x_raddr),   e_addr[0]);
            chk("a_en",    int'(a_if.mac_en),    int'(e_en[0]));
            chk("a_first", int'(a_if.mac_first), int'(e_first[0]));
            chk("a_last",  int'(a_if.mac_last),  int'(e_last[0]));
            chk("b_busy",  int'(b_if.busy),      int'(e_busy[1]));
            chk("b_done",  int'(b_if.done),      int'(e_done[1]));
            chk("b_waddr", int'(b_if.w7_raddr),  e_addr[1]);
            chk("b_xaddr", int'(b_if.x_raddr),   e_addr[1]);
            chk("b_en",    int'(b_if.mac_en),    int'(e_en[1]));
            chk("b_first", int'(b_if.mac_first), int'(e_first[1]));
            chk("b_last",  int'(b_if.mac_last),  int'(e_last[1]));
        end
    end

    // ---------------- memory model + accumulators for instance A ----------------
    logic signed [7:0] rom [84][10];
    logic [6:0] w_q, x_q;
    int acc[10];

    always @(posedge clk) begin
        w_q <= a_if.w7_raddr;
        x_q <= a_if.x_raddr;
    end

    always @(negedge clk) begin
        if (a_if.mac_en === 1'b1 && int'(w_q) < 84) begin
            for (int j = 0; j < 10; j++) begin
                int p;
                p = int'(rom[w_q][j]) * int'(x_q);
                acc[j] = (a_if.mac_first === 1'b1) ? p : acc[j] + p;
            end
        end
    end

    function automatic int golden(input int j);
        int s = 0;
        for (int k = 0; k < 84; k++) s += int'(rom[k][j]) * k;
        return s;
    endfunction

    task automatic check_acc(input string tag);
        for (int j = 0; j < 10; j++) chk($sformatf("%s_acc%0d", tag, j), acc[j], golden(j));
    endtask

    // ---------------- stimulus helpers ----------------
    int  lg_addr[400];
    bit  lg_en[400], lg_first[400], lg_last[400], lg_done[400], lg_busy[400];

    task automatic drive_b();
        if (b_rand_on) begin
            b_if.start = ($urandom_range(99) < 20);
            b_if.hold  = ($urandom_range(99) < 30);
            b_rst      = ($urandom_range(99) < 3);
        end
    endtask

    task automatic sample(input int id, input int r);
        if (id == 0) begin
            lg_addr[r] = int'(a_if.w7_raddr); lg_en[r] = a_if.mac_en;
            lg_first[r] = a_if.mac_first; lg_last[r] = a_if.mac_last;
            lg_done[r] = a_if.done; lg_busy[r] = a_if.busy;
        end else begin
            lg_addr[r] = int'(b_if.w7_raddr); lg_en[r] = b_if.mac_en;
            lg_first[r] = b_if.mac_first; lg_last[r] = b_if.mac_last;
            lg_done[r] = b_if.done; lg_busy[r] = b_if.busy;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a_if.start = 1'b0; a_if.hold = 1'b0; a_rst = 1'b0;
            drive_b();
        end
    endtask

    // One window on instance A; rel cycle 0 is the cycle start is first driven.
    task automatic run_a(input int len, input int start_len, input int pulse_at,
                         input int hold_lo, input int hold_hi, input int hold_pct,
                         input int rst_at);
        for (int r = 0; r < len; r++) begin
            @(negedge clk);
            sample(0, r);
            a_if.start = (r < start_len) || (r == pulse_at);
            a_if.hold  = (r >= hold_lo && r <= hold_hi) || (int'($urandom_range(99)) < hold_pct);
            a_rst      = (r == rst_at);
            drive_b();
        end
        a_if.start = 1'b0; a_if.hold = 1'b0; a_rst = 1'b0;
    endtask

    task automatic summarize(input int len, output int n_str, output int f_at,
                             output int l_at, output int d_at, output int n_done);
        n_str = 0; f_at = -1; l_at = -1; d_at = -1; n_done = 0;
        for (int r = 0; r < len; r++) begin
            if (lg_en[r]) n_str++;
            if (lg_first[r] && f_at < 0) f_at = r;
            if (lg_last[r]) l_at = r;
            if (lg_done[r]) begin
                n_done++;
                if (d_at < 0) d_at = r;
            end
        end
    endtask

    int n_str, f_at, l_at, d_at, n_done;

    initial begin
        for (int k = 0; k < 84; k++)
            for (int j = 0; j < 10; j++)
                rom[k][j] = 8'((k * 37 + j * 59 + k * j + 11) & 255);
        for (int j = 0; j < 10; j++) acc[j] = 0;
        a_if.start = 1'b0; a_if.hold = 1'b0;
        b_if.start = 1'b0; b_if.hold = 1'b0;

        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        a_rst = 1'b0; b_rst = 1'b0;
        chk("rst_a_busy", int'(a_if.busy), 0);
        chk("rst_a_addr", int'(a_if.w7_raddr), 0);
        chk("rst_a_en",   int'(a_if.mac_en), 0);
        chk("rst_b_done", int'(b_if.done), 0);

        // Instance B: N_IN=4, RD_LAT=3 directed pass.
        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            sample(1, r);
            b_if.start = (r == 0);
        end
        for (int r = 1; r <= 4; r++) chk($sformatf("b_addr_at%0d", r), lg_addr[r], r - 1);
        summarize(12, n_str, f_at, l_at, d_at, n_done);
        chk("b_nstrobe", n_str, 4);
        chk("b_first_at", f_at, 4);
        chk("b_last_at", l_at, 7);
        chk("b_done_at", d_at, 8);
        chk("b_en_at3", int'(lg_en[3]), 0);
        chk("b_en_at8", int'(lg_en[8]), 0);
        chk("b_addr_hold_after", lg_addr[11], 3);
        b_rand_on = 1'b1;

        // 1: plain pass, with a start pulse mid-pass that must be ignored.
        run_a(100, 1, 40, -1, -1, 0, -1);
        summarize(100, n_str, f_at, l_at, d_at, n_done);
        chk("t1_addr_at1", lg_addr[1], 0);
        chk("t1_addr_at84", lg_addr[84], 83);
        chk("t1_addr_at99", lg_addr[99], 83);
        chk("t1_nstrobe", n_str, 84);
        chk("t1_first_at", f_at, 2);
        chk("t1_last_at", l_at, 85);
        chk("t1_done_at", d_at, 86);
        chk("t1_ndone", n_done, 1);
        chk("t1_busy_at1", int'(lg_busy[1]), 1);
        chk("t1_busy_at86", int'(lg_busy[86]), 1);
        chk("t1_busy_at87", int'(lg_busy[87]), 0);
        check_acc("t1");
        idle(5);

        // 2: hold for 5 cycles while address 8 is out.
        run_a(100, 1, -1, 9, 13, 0, -1);
        summarize(100, n_str, f_at, l_at, d_at, n_done);
        for (int r = 10; r <= 14; r++) chk($sformatf("t2_addr_at%0d", r), lg_addr[r], 8);
        chk("t2_addr_at15", lg_addr[15], 9);
        chk("t2_nstrobe", n_str, 84);
        chk("t2_done_at", d_at, 91);
        check_acc("t2");
        idle(5);

        // 3: start held high for 200 cycles.
        run_a(300, 200, -1, -1, -1, 0, -1);
        summarize(300, n_str, f_at, l_at, d_at, n_done);
        chk("t3_ndone", n_done, 3);
        chk("t3_done_at86", int'(lg_done[86]), 1);
        chk("t3_busy_at87", int'(lg_busy[87]), 0);
        chk("t3_addr_at88", lg_addr[88], 0);
        chk("t3_done_at173", int'(lg_done[173]), 1);
        chk("t3_done_at260", int'(lg_done[260]), 1);
        chk("t3_nstrobe", n_str, 252);
        idle(5);

        // 4: reset mid-pass, then a fresh pass.
        run_a(130, 1, -1, -1, -1, 0, 30);
        summarize(130, n_str, f_at, l_at, d_at, n_done);
        chk("t4_busy_at31", int'(lg_busy[31]), 0);
        chk("t4_addr_at31", lg_addr[31], 0);
        chk("t4_en_at31", int'(lg_en[31]), 0);
        chk("t4_nstrobe", n_str, 29);
        chk("t4_ndone", n_done, 0);
        run_a(100, 1, -1, -1, -1, 0, -1);
        summarize(100, n_str, f_at, l_at, d_at, n_done);
        chk("t4b_nstrobe", n_str, 84);
        chk("t4b_done_at", d_at, 86);
        idle(5);

        // 6: random 30% hold, accumulators against golden dot products.
        for (int p = 0; p < 3; p++) begin
            run_a(350, 1, -1, -1, -1, 30, -1);
            summarize(350, n_str, f_at, l_at, d_at, n_done);
            chk("t6_nstrobe", n_str, 84);
            chk("t6_ndone", n_done, 1);
            chk("t6_first_at", f_at, (d_at > 0) ? f_at : -2);
            check_acc("t6");
            idle(5);
        end

        b_rand_on = 1'b0;
        idle(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
